// File: rtl/sap1_ctrl_pkg.sv
// SAP-1 run/step controller shared types.
// States, stop causes and the T-state wrap helper.
package sap1_ctrl_pkg;

  localparam int TSTATES_DEFAULT = 6;

  typedef enum logic [1:0] {
    STOPPED = 2'd0,
    RUN     = 2'd1,
    DRAIN   = 2'd2,
    HALTED  = 2'd3
  } state_e;

  typedef enum logic {
    CAUSE_PROG = 1'b0,
    CAUSE_HALT = 1'b1
  } cause_e;

  function automatic logic [2:0] tstate_next(
    input logic [2:0] t,
    input logic [2:0] last
  );
    return (t == last) ? 3'd0 : t + 3'd1;
  endfunction

endpackage

// File: rtl/sap1_run_ctrl_if.sv
// Board-side request/enable bundle for the SAP-1 run controller.
// master = board and core side, slave = controller.
interface sap1_run_ctrl_if #(
  parameter int CYC_W = 16
);

  logic             tick;
  logic             tick_oop;
  logic             step_rise;
  logic             step_fall;
  logic             manual;
  logic             instr_step;
  logic             fp_clear;
  logic             prog;
  logic             halt;
  logic             clken;
  logic             clken_oop;
  logic             running;
  logic             halted;
  logic [2:0]       tstate;
  logic [CYC_W-1:0] cycle_count;

  modport master (
    output tick, tick_oop,
    output step_rise, step_fall,
    output manual, instr_step,
    output fp_clear, prog, halt,
    input  clken, clken_oop,
    input  running, halted,
    input  tstate, cycle_count
  );

  modport slave (
    input  tick, tick_oop,
    input  step_rise, step_fall,
    input  manual, instr_step,
    input  fp_clear, prog, halt,
    output clken, clken_oop,
    output running, halted,
    output tstate, cycle_count
  );

endinterface

// File: rtl/sap1_run_ctrl_phase_pair.sv
// Rise/fall clock-enable pair for the SAP-1 core.
// The half flag forces strict clken/clken_oop alternation.
module sap1_phase_pair (
  input  logic sysclk,
  input  logic clr_n,
  input  logic enable,
  input  logic rise_req,
  input  logic fall_req,
  output logic clken,
  output logic clken_oop,
  output logic half
);

  logic rise_ok;
  logic fall_ok;

  assign rise_ok = enable & rise_req & ~half;
  assign fall_ok = enable & fall_req & half;

  always_ff @(posedge sysclk or negedge clr_n) begin
    if (!clr_n) begin
      clken     <= 1'b0;
      clken_oop <= 1'b0;
      half      <= 1'b0;
    end else begin
      clken     <= rise_ok;
      clken_oop <= fall_ok;
      if (rise_ok)
        half <= 1'b1;
      else if (fall_ok)
        half <= 1'b0;
    end
  end

endmodule

// File: rtl/sap1_run_ctrl.sv
// SAP-1 run/stop/halt controller: picks the phase source,
// owns the FSM, T-state and completed-cycle counters.
module sap1_run_ctrl
  import sap1_ctrl_pkg::*;
#(
  parameter int TSTATES = TSTATES_DEFAULT,
  parameter int CYC_W   = 16
) (
  input logic          sysclk,
  input logic          clr_n,
  sap1_run_ctrl_if.slave bus
);

  localparam logic [2:0] T_LAST = 3'(TSTATES - 1);

  state_e           state_q;
  state_e           state_d;
  cause_e           cause_q;
  cause_e           cause_d;
  logic             burst_q;
  logic             burst_d;
  logic             fp_q;
  logic             fp_rise;
  logic             clr_cnt;
  logic             half;
  logic             clken;
  logic             clken_oop;
  logic             src_rise;
  logic             src_fall;
  logic             stop_req;
  logic             instr_mode;
  logic             run_ok;
  logic             in_drain;
  logic             wrap;
  logic [2:0]       tstate_q;
  logic [CYC_W-1:0] cyc_q;

  assign fp_rise    = bus.fp_clear & ~fp_q;
  assign stop_req   = bus.halt | bus.prog;
  assign instr_mode = bus.manual & bus.instr_step;
  assign run_ok     = (state_q == RUN) & ~stop_req;
  assign in_drain   = (state_q == DRAIN);
  assign wrap       = clken_oop & (tstate_q == T_LAST);

  // Instruction mode outside a burst only lets a
  // stranded fall phase complete from the button.
  always_comb begin
    src_rise = 1'b0;
    src_fall = 1'b0;
    unique case (1'b1)
      !bus.manual: begin
        src_rise = bus.tick;
        src_fall = bus.tick_oop;
      end
      bus.manual && !bus.instr_step: begin
        src_rise = bus.step_rise;
        src_fall = bus.step_fall;
      end
      instr_mode && burst_q: begin
        src_rise = bus.tick;
        src_fall = bus.tick_oop;
      end
      instr_mode && !burst_q: begin
        src_fall = bus.step_fall;
      end
      default: ;
    endcase
  end

  sap1_phase_pair u_pair (
    .sysclk    (sysclk),
    .clr_n     (clr_n),
    .enable    (run_ok | in_drain),
    .rise_req  (src_rise & run_ok),
    .fall_req  (src_fall),
    .clken     (clken),
    .clken_oop (clken_oop),
    .half      (half)
  );

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    burst_d = burst_q;
    clr_cnt = 1'b0;
    unique case (state_q)
      STOPPED: begin
        if (fp_rise && !bus.prog && !bus.halt) begin
          state_d = RUN;
          burst_d = 1'b0;
          clr_cnt = 1'b1;
        end
      end
      RUN: begin
        if (stop_req) begin
          burst_d = 1'b0;
          if (half) begin
            state_d = DRAIN;
            cause_d = bus.halt ? CAUSE_HALT : CAUSE_PROG;
          end else begin
            state_d = bus.halt ? HALTED : STOPPED;
          end
        end else if (!instr_mode) begin
          burst_d = 1'b0;
        end else if (!burst_q) begin
          if (bus.step_rise && !half)
            burst_d = 1'b1;
        end else if (wrap) begin
          burst_d = 1'b0;
        end
      end
      DRAIN: begin
        if (src_fall && half)
          state_d = (cause_q == CAUSE_HALT) ? HALTED : STOPPED;
      end
      HALTED: begin
        if (bus.prog) begin
          state_d = STOPPED;
        end else if (fp_rise && !bus.halt) begin
          state_d = RUN;
          burst_d = 1'b0;
          clr_cnt = 1'b1;
        end
      end
      default: state_d = STOPPED;
    endcase
  end

  always_ff @(posedge sysclk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= STOPPED;
      cause_q <= CAUSE_PROG;
      burst_q <= 1'b0;
      fp_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      burst_q <= burst_d;
      fp_q    <= bus.fp_clear;
    end
  end

  // A restart clear outranks a late drain fall phase.
  always_ff @(posedge sysclk or negedge clr_n) begin
    if (!clr_n) begin
      tstate_q <= 3'd0;
      cyc_q    <= '0;
    end else if (clr_cnt) begin
      tstate_q <= 3'd0;
      cyc_q    <= '0;
    end else if (clken_oop) begin
      tstate_q <= tstate_next(tstate_q, T_LAST);
      if (cyc_q != '1)
        cyc_q <= cyc_q + 1'b1;
    end
  end

  assign bus.clken       = clken;
  assign bus.clken_oop   = clken_oop;
  assign bus.running     = (state_q == RUN) | in_drain;
  assign bus.halted      = (state_q == HALTED);
  assign bus.tstate      = tstate_q;
  assign bus.cycle_count = cyc_q;

endmodule

// File: tb/tb_sap1_run_ctrl.sv
// Directed bench for sap1_run_ctrl: a 16-bit and a 4-bit
// counter instance share one stimulus stream.
module tb_sap1_run_ctrl;

  localparam int TK = 0;
  localparam int TO = 1;
  localparam int SR = 2;
  localparam int SF = 3;

  logic CLOCK_100MHZ = 1'b0;
  logic clr_n = 1'b0;

  always #5 CLOCK_100MHZ = ~CLOCK_100MHZ;

  sap1_run_ctrl_if #(.CYC_W(16)) bus ();
  sap1_run_ctrl_if #(.CYC_W(4))  bus4 ();

  assign bus4.tick       = bus.tick;
  assign bus4.tick_oop   = bus.tick_oop;
  assign bus4.step_rise  = bus.step_rise;
  assign bus4.step_fall  = bus.step_fall;
  assign bus4.manual     = bus.manual;
  assign bus4.instr_step = bus.instr_step;
  assign bus4.fp_clear   = bus.fp_clear;
  assign bus4.prog       = bus.prog;
  assign bus4.halt       = bus.halt;

  sap1_run_ctrl #(.TSTATES(6), .CYC_W(16)) dut (
    .sysclk (CLOCK_100MHZ),
    .clr_n  (clr_n),
    .bus    (bus.slave)
  );

  sap1_run_ctrl #(.TSTATES(6), .CYC_W(4)) dut4 (
    .sysclk (CLOCK_100MHZ),
    .clr_n  (clr_n),
    .bus    (bus4.slave)
  );

  int   ntests = 0;
  int   nfail  = 0;
  int   n_rise = 0;
  int   n_fall = 0;
  int   r0;
  int   f0;
  logic mh = 1'b0;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Independent alternation/overlap watch on dut.
  always @(negedge CLOCK_100MHZ) begin
    if (!clr_n) begin
      mh = 1'b0;
    end else if (bus.clken || bus.clken_oop) begin
      chk("overlap", 32'(bus.clken & bus.clken_oop), 32'd0);
      if (bus.clken) begin
        n_rise++;
        chk("alt_rise", 32'(mh), 32'd0);
        mh = 1'b1;
      end
      if (bus.clken_oop) begin
        n_fall++;
        chk("alt_fall", 32'(mh), 32'd1);
        mh = 1'b0;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge CLOCK_100MHZ);
      #1;
    end
  endtask

  task automatic pulse(input int w);
    case (w)
      TK: bus.tick = 1'b1;
      TO: bus.tick_oop = 1'b1;
      SR: bus.step_rise = 1'b1;
      SF: bus.step_fall = 1'b1;
      default: ;
    endcase
    cyc(1);
    bus.tick      = 1'b0;
    bus.tick_oop  = 1'b0;
    bus.step_rise = 1'b0;
    bus.step_fall = 1'b0;
  endtask

  task automatic pairs(input int a, input int b, input int n);
    repeat (n) begin
      pulse(a);
      cyc(3);
      pulse(b);
      cyc(3);
    end
  endtask

  initial begin
    bus.tick       = 1'b0;
    bus.tick_oop   = 1'b0;
    bus.step_rise  = 1'b0;
    bus.step_fall  = 1'b0;
    bus.manual     = 1'b0;
    bus.instr_step = 1'b0;
    bus.fp_clear   = 1'b0;
    bus.prog       = 1'b0;
    bus.halt       = 1'b0;
    cyc(3);

    chk("rst_clken", 32'(bus.clken), 32'd0);
    chk("rst_clken_oop", 32'(bus.clken_oop), 32'd0);
    chk("rst_running", 32'(bus.running), 32'd0);
    chk("rst_halted", 32'(bus.halted), 32'd0);
    chk("rst_tstate", 32'(bus.tstate), 32'd0);
    chk("rst_cycles", 32'(bus.cycle_count), 32'd0);

    clr_n = 1'b1;
    cyc(2);
    bus.fp_clear = 1'b1;
    cyc(1);
    chk("start_running", 32'(bus.running), 32'd1);
    bus.fp_clear = 1'b0;
    cyc(1);

    // auto run, 5 pairs
    pulse(TK);
    chk("t1_clken", 32'(bus.clken), 32'd1);
    chk("t1_no_oop", 32'(bus.clken_oop), 32'd0);
    cyc(1);
    chk("t1_clken_w", 32'(bus.clken), 32'd0);
    cyc(2);
    pulse(TO);
    chk("t1_oop", 32'(bus.clken_oop), 32'd1);
    cyc(1);
    chk("t1_oop_w", 32'(bus.clken_oop), 32'd0);
    cyc(2);
    pairs(TK, TO, 4);
    chk("t1_tstate", 32'(bus.tstate), 32'd5);
    chk("t1_cycles", 32'(bus.cycle_count), 32'd5);
    chk("t1_nrise", 32'(n_rise), 32'd5);
    chk("t1_nfall", 32'(n_fall), 32'd5);
    chk("t1_running", 32'(bus.running), 32'd1);

    // halt mid-cycle drains one fall phase
    pulse(TK);
    bus.halt = 1'b1;
    cyc(1);
    chk("t2_drain_run", 32'(bus.running), 32'd1);
    chk("t2_drain_hlt", 32'(bus.halted), 32'd0);
    cyc(2);
    pulse(TO);
    chk("t2_drain_oop", 32'(bus.clken_oop), 32'd1);
    cyc(2);
    chk("t2_halted", 32'(bus.halted), 32'd1);
    chk("t2_not_run", 32'(bus.running), 32'd0);
    chk("t2_tstate", 32'(bus.tstate), 32'd0);
    chk("t2_cycles", 32'(bus.cycle_count), 32'd6);
    r0 = n_rise;
    f0 = n_fall;
    pairs(TK, TO, 10);
    chk("t2_no_rise", 32'(n_rise), 32'(r0));
    chk("t2_no_fall", 32'(n_fall), 32'(f0));
    bus.fp_clear = 1'b1;
    cyc(1);
    chk("t2_halt_beats_fp", 32'(bus.halted), 32'd1);
    bus.fp_clear = 1'b0;
    bus.halt = 1'b0;
    cyc(1);
    bus.fp_clear = 1'b1;
    cyc(1);
    chk("t2_rerun", 32'(bus.running), 32'd1);
    chk("t2_rerun_hlt", 32'(bus.halted), 32'd0);
    chk("t2_rerun_cyc", 32'(bus.cycle_count), 32'd0);
    bus.fp_clear = 1'b0;
    cyc(1);

    // manual single step
    pairs(TK, TO, 2);
    chk("t3_tstate0", 32'(bus.tstate), 32'd2);
    bus.manual = 1'b1;
    cyc(1);
    r0 = n_rise;
    f0 = n_fall;
    pulse(SR);
    chk("t3_clken", 32'(bus.clken), 32'd1);
    cyc(2);
    pulse(TK);
    cyc(2);
    pulse(TO);
    cyc(2);
    chk("t3_tick_rise", 32'(n_rise), 32'(r0 + 1));
    chk("t3_tick_fall", 32'(n_fall), 32'(f0));
    pulse(SF);
    chk("t3_oop", 32'(bus.clken_oop), 32'd1);
    cyc(2);
    chk("t3_tstate", 32'(bus.tstate), 32'd3);

    // instruction step burst
    pairs(SR, SF, 5);
    chk("t4_tstate0", 32'(bus.tstate), 32'd2);
    bus.instr_step = 1'b1;
    cyc(1);
    r0 = n_rise;
    pulse(SR);
    chk("t4_no_clken", 32'(bus.clken), 32'd0);
    cyc(2);
    pulse(SF);
    cyc(2);
    chk("t4_press_only", 32'(n_rise), 32'(r0));
    pairs(TK, TO, 2);
    pairs(SR, SF, 1);
    pairs(TK, TO, 2);
    chk("t4_wrap", 32'(bus.tstate), 32'd0);
    chk("t4_burst_n", 32'(n_rise), 32'(r0 + 4));
    pairs(TK, TO, 2);
    chk("t4_idle_n", 32'(n_rise), 32'(r0 + 4));
    chk("t4_idle_t", 32'(bus.tstate), 32'd0);

    // mode change with a fall phase pending
    bus.instr_step = 1'b0;
    cyc(1);
    pulse(SR);
    chk("t5_clken", 32'(bus.clken), 32'd1);
    cyc(2);
    bus.manual = 1'b0;
    cyc(1);
    r0 = n_rise;
    f0 = n_fall;
    pulse(SF);
    cyc(2);
    chk("t5_sf_ignored", 32'(n_fall), 32'(f0));
    pulse(TK);
    cyc(2);
    chk("t5_no_double", 32'(n_rise), 32'(r0));
    pulse(TO);
    chk("t5_oop", 32'(bus.clken_oop), 32'd1);
    cyc(2);
    chk("t5_tstate", 32'(bus.tstate), 32'd1);
    chk("t5_cycles", 32'(bus.cycle_count), 32'd13);

    // prog stop, prog beats fp_clear, saturation
    bus.prog = 1'b1;
    cyc(2);
    chk("t6_stopped", 32'(bus.running), 32'd0);
    chk("t6_not_hlt", 32'(bus.halted), 32'd0);
    bus.fp_clear = 1'b1;
    cyc(1);
    chk("t6_prog_fp", 32'(bus.running), 32'd0);
    bus.fp_clear = 1'b0;
    r0 = n_rise;
    pairs(TK, TO, 2);
    chk("t6_no_rise", 32'(n_rise), 32'(r0));
    chk("t6_cyc_kept", 32'(bus.cycle_count), 32'd13);
    bus.prog = 1'b0;
    cyc(1);
    bus.fp_clear = 1'b1;
    cyc(1);
    chk("t6_run", 32'(bus.running), 32'd1);
    chk("t6_cyc_clr", 32'(bus.cycle_count), 32'd0);
    bus.fp_clear = 1'b0;
    pairs(TK, TO, 20);
    chk("t6_cyc16", 32'(bus.cycle_count), 32'd20);
    chk("t6_cyc4_sat", 32'(bus4.cycle_count), 32'd15);
    chk("t6_tstate", 32'(bus.tstate), 32'd2);
    chk("t6_tstate4", 32'(bus4.tstate), 32'd2);

    // reset while a fall phase is pending
    pulse(TK);
    chk("t7_clken", 32'(bus.clken), 32'd1);
    clr_n = 1'b0;
    cyc(2);
    chk("t7_rst_run", 32'(bus.running), 32'd0);
    chk("t7_rst_t", 32'(bus.tstate), 32'd0);
    clr_n = 1'b1;
    cyc(1);
    bus.fp_clear = 1'b1;
    cyc(1);
    bus.fp_clear = 1'b0;
    f0 = n_fall;
    pulse(TO);
    cyc(2);
    chk("t7_abandon", 32'(n_fall), 32'(f0));
    pulse(TK);
    chk("t7_fresh", 32'(bus.clken), 32'd1);
    cyc(2);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/sap1_run_ctrl.md
Name: sap1_run_ctrl

Overview:
- Run/step controller that sequences the SAP-1 core's two clock-enable phases (clken, clken_oop) from the free-running 1 kHz tick pair or the debounced single-step button.
- Owns the run/stop/halt state, enforces strict rise/fall phase pairing, and supports whole-instruction stepping.
- Sits between the board-level debouncers/clock-enable generator and the sap1 core, replacing ad-hoc gating logic.

Parameters:
- TSTATES, 6, T-states per instruction (2..8); sets the instruction-step burst length and the tstate wrap point.
- CYC_W, 16, width of the completed-cycle counter.

Ports:
- sysclk  in  1  system clock (100 MHz); all logic on posedge.
- clr_n  in  1  reset, asynchronous, active-low.
- tick  in  1  1 kHz rise-phase enable pulse, one sysclk wide.
- tick_oop  in  1  1 kHz fall-phase enable pulse, half-period offset from tick.
- step_rise  in  1  debounced step-button press pulse.
- step_fall  in  1  debounced step-button release pulse.
- manual  in  1  1 = manual stepping, 0 = auto.
- instr_step  in  1  in manual mode, one press runs a full instruction.
- fp_clear  in  1  debounced clear/start level; the block detects its rising edge internally.
- prog  in  1  program mode; forces stop.
- halt  in  1  HLT decoded by the core (level).
- clken  out  1  rise-phase enable to the core.
- clken_oop  out  1  fall-phase enable to the core.
- running  out  1  high in RUN or DRAIN.
- halted  out  1  high in HALTED.
- tstate  out  3  current T-state index, 0..TSTATES-1.
- cycle_count  out  CYC_W  completed clock cycles since start.

Behaviour:
- Reset:
  - state=STOPPED, half=0, burst=0.
  - All outputs 0, including tstate and cycle_count.
- half flag:
  - Set by clken; cleared by clken_oop.
  - clken can issue only when half=0; clken_oop can issue only when half=1.
  - clken and clken_oop are never high in the same cycle.
- Latency: both outputs are registered, one sysclk after the qualifying source pulse; each is exactly one cycle wide.
- Pulse sources in RUN:
  - manual=0: tick / tick_oop.
  - manual=1, instr_step=0: step_rise / step_fall.
  - manual=1, instr_step=1: step_rise with half=0 sets burst=1. While burst=1, tick / tick_oop drive the phases. burst clears on the clken_oop that wraps tstate to 0; step pulses are ignored during the burst.
  - A mode change while half=1: the pending clken_oop comes from the new mode's source.
- Counters:
  - On each clken_oop, tstate increments and wraps TSTATES-1 to 0.
  - On each clken_oop, cycle_count increments and saturates at all-ones.
- States:
  - STOPPED:
    - fp_clear rise with prog=0 and halt=0 goes to RUN; tstate and cycle_count clear that cycle.
    - fp_clear rise with prog=1 is ignored.
  - RUN: issues phases per the source rules above.
    - halt=1 or prog=1: if half=0, go directly to HALTED (halt) or STOPPED (prog) with no further clken. If half=1, go to DRAIN.
  - DRAIN:
    - Issues only the pending clken_oop, from the current source.
    - Then goes to HALTED if halt was the cause, else STOPPED.
    - Halt takes precedence over prog in the recorded cause.
  - HALTED:
    - Outputs clken=0 and clken_oop=0.
    - fp_clear rise with prog=0 and halt=0 goes to RUN with counters cleared; prog=1 goes to STOPPED.
- Simultaneous events:
  - halt beats fp_clear rise in the same cycle.
  - prog beats fp_clear rise.
  - A source pulse arriving in the cycle the state leaves RUN is dropped, except the DRAIN clken_oop.
- Reset mid-cycle (clr_n low with half=1): the pending phase is abandoned. No clken_oop is issued after release.

Decomposition:
- Package sap1_ctrl_pkg:
  - state enum {STOPPED, RUN, DRAIN, HALTED}.
  - TSTATES_DEFAULT=6.
  - Stop-cause encoding.
- One sub-module, sap1_phase_pair:
  - Holds the half flag and the registered clken/clken_oop.
  - Takes rise_req/fall_req/enable.
  - Guarantees alternation.
  - The top FSM selects the source and handles counters and state.

Test Plan:
1. Reset, then fp_clear rise, manual=0, 5 tick/tick_oop pairs -> 5 clken and 5 clken_oop alternating at +1 cycle each; tstate=5; cycle_count=5; running=1.
2. Assert halt one cycle after a clken (half=1) -> exactly one more clken_oop (from DRAIN), then halted=1 and no further clken over 10 ticks; fp_clear rise with halt=0 -> RUN, cycle_count=0.
3. manual=1, instr_step=0, tstate=2: press then release -> one clken, one clken_oop, tstate=3; ticks during the press produce nothing.
4. manual=1, instr_step=1, tstate=2: one step_rise -> 4 tick-driven pairs, tstate wraps to 0, burst ends; further ticks produce nothing; a second press mid-burst is ignored.
5. Switch manual to 0 while half=1 -> the next tick_oop (not step_fall) yields clken_oop; no double clken.
6. prog=1 and fp_clear rise in the same cycle, from STOPPED -> stays STOPPED; CYC_W=4 with 20 pairs -> cycle_count saturates at 15.
